// File: rtl/tsic_pkg.sv
// Shared types and constants for the TSIC command sequencer.
// Opcodes, FSM states and fixed response words.
package tsic_pkg;

  typedef enum logic [3:0] {
    OP_WR_OFF  = 4'h0,
    OP_WR_GAIN = 4'h1,
    OP_RD_TEMP = 4'h2,
    OP_RD_AVG  = 4'h3,
    OP_RD_OFF  = 4'h4,
    OP_RD_GAIN = 4'h5
  } opcode_e;

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_WAIT_CNV,
    S_CALC,
    S_SEND,
    S_WAIT_TX
  } state_e;

  localparam logic [15:0] RESP_ILLEGAL = 16'hEEEE;
  localparam logic [15:0] RESP_TIMEOUT = 16'hFFFF;
  localparam logic [7:0]  GAIN_RESET   = 8'h80;

endpackage

// File: rtl/tsic_cal_math.sv
// Calibration datapath: average, signed offset, Q1.7 gain.
// Both stages saturate to the 12-bit range 0..4095.
module tsic_cal_math (
  input  logic [13:0] acc,
  input  logic [2:0]  cnt,
  input  logic [11:0] offset,
  input  logic [7:0]  gain,
  output logic [11:0] temp
);

  logic [11:0]        avg;
  logic signed [13:0] s;
  logic [11:0]        sc;
  logic [19:0]        sh;

  always_comb begin
    avg = (cnt == 3'd4) ? acc[13:2] : acc[11:0];
    s   = $signed({2'b00, avg}) +
          $signed({{2{offset[11]}}, offset});
    if (s < 14'sd0) begin
      sc = 12'h000;
    end else if (s > 14'sd4095) begin
      sc = 12'hFFF;
    end else begin
      sc = s[11:0];
    end
    sh   = ({8'h00, sc} * {12'h000, gain}) >> 7;
    temp = (sh > 20'd4095) ? 12'hFFF : sh[11:0];
  end

endmodule

// File: rtl/tsic_seq.sv
// TSIC command sequencer: decodes host commands, holds
// calibration registers and sequences A2D conversions.
module tsic_seq
  import tsic_pkg::*;
#(
  parameter int CNV_TIMEOUT = 1024
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cmd_rdy,
  input  logic [15:0] cmd,
  input  logic        tx_done,
  output logic        trmt,
  output logic [15:0] resp,
  output logic        strt_cnv,
  input  logic        cnv_cmplt,
  input  logic [11:0] a2d_raw,
  output logic        busy
);

  localparam int TW = $clog2(CNV_TIMEOUT) + 1;
  localparam logic [TW-1:0] TMO_LAST = TW'(CNV_TIMEOUT - 1);

  state_e        state_q, state_d;
  logic [3:0]    op_q, op_d;
  logic [11:0]   off_q, off_d;
  logic [7:0]    gain_q, gain_d;
  logic [13:0]   acc_q, acc_d;
  logic [2:0]    cnt_q, cnt_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic [15:0]   resp_q, resp_d;
  logic          trmt_q, trmt_d;
  logic          strt_q, strt_d;
  logic          busy_q, busy_d;
  logic [2:0]    target;
  logic [11:0]   temp;

  tsic_cal_math u_cal (
    .acc    (acc_q),
    .cnt    (cnt_q),
    .offset (off_q),
    .gain   (gain_q),
    .temp   (temp)
  );

  assign target = (op_q == OP_RD_AVG) ? 3'd4 : 3'd1;

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    off_d   = off_q;
    gain_d  = gain_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    tmo_d   = tmo_q;
    resp_d  = resp_q;
    unique case (state_q)
      S_IDLE: begin
        if (cmd_rdy) begin
          op_d    = cmd[15:12];
          state_d = S_SEND;
          case (cmd[15:12])
            OP_WR_OFF: begin
              off_d  = cmd[11:0];
              resp_d = {4'h0, cmd[11:0]};
            end
            OP_WR_GAIN: begin
              gain_d = cmd[7:0];
              resp_d = {8'h10, cmd[7:0]};
            end
            OP_RD_TEMP, OP_RD_AVG: begin
              acc_d   = '0;
              cnt_d   = '0;
              state_d = S_START;
            end
            OP_RD_OFF:  resp_d = {4'h4, off_q};
            OP_RD_GAIN: resp_d = {8'h50, gain_q};
            default:    resp_d = RESP_ILLEGAL;
          endcase
        end
      end
      S_START: begin
        tmo_d   = '0;
        state_d = S_WAIT_CNV;
      end
      S_WAIT_CNV: begin
        tmo_d = tmo_q + TW'(1);
        // timeout wins over a completion in the same cycle
        if (tmo_q == TMO_LAST) begin
          resp_d  = RESP_TIMEOUT;
          state_d = S_SEND;
        end else if (cnv_cmplt) begin
          acc_d   = acc_q + {2'b00, a2d_raw};
          cnt_d   = cnt_q + 3'd1;
          state_d = (cnt_d < target) ? S_START : S_CALC;
        end
      end
      S_CALC: begin
        resp_d  = {(op_q == OP_RD_AVG) ? 4'h3 : 4'h2, temp};
        state_d = S_SEND;
      end
      S_SEND: state_d = S_WAIT_TX;
      S_WAIT_TX: begin
        if (tx_done) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    trmt_d = (state_d == S_SEND);
    strt_d = (state_d == S_START);
    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      op_q    <= '0;
      off_q   <= '0;
      gain_q  <= GAIN_RESET;
      acc_q   <= '0;
      cnt_q   <= '0;
      tmo_q   <= '0;
      resp_q  <= '0;
      trmt_q  <= 1'b0;
      strt_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      off_q   <= off_d;
      gain_q  <= gain_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      tmo_q   <= tmo_d;
      resp_q  <= resp_d;
      trmt_q  <= trmt_d;
      strt_q  <= strt_d;
      busy_q  <= busy_d;
    end
  end

  assign trmt     = trmt_q;
  assign resp     = resp_q;
  assign strt_cnv = strt_q;
  assign busy     = busy_q;

endmodule

// File: tb/tb_tsic_seq.sv
// Bench for tsic_seq: directed and random commands checked
// against an arithmetic model of the calibration rules.
module tb_tsic_seq;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cmd_rdy = 1'b0;
  logic [15:0] cmd = '0;
  logic        tx_done = 1'b0;
  logic        cnv_cmplt = 1'b0;
  logic [11:0] a2d_raw = '0;
  logic        trmt, strt_cnv, busy;
  logic [15:0] resp;

  int n_vec = 0;
  int n_err = 0;
  int m_off = 0;
  int m_gain = 128;

  always #5 clk = ~clk;

  tsic_seq #(.CNV_TIMEOUT(1024)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .cmd_rdy   (cmd_rdy),
    .cmd       (cmd),
    .tx_done   (tx_done),
    .trmt      (trmt),
    .resp      (resp),
    .strt_cnv  (strt_cnv),
    .cnv_cmplt (cnv_cmplt),
    .a2d_raw   (a2d_raw),
    .busy      (busy)
  );

  function automatic int model_temp(int sum, int n, int off, int gain);
    int s, t;
    s = sum / n + ((off >= 2048) ? off - 4096 : off);
    if (s < 0) s = 0;
    if (s > 4095) s = 4095;
    t = (s * gain) / 128;
    if (t > 4095) t = 4095;
    return t;
  endfunction

  task automatic simple_exp(input logic [15:0] c, output logic [15:0] e);
    case (c[15:12])
      4'h0: begin m_off = int'(c[11:0]); e = {4'h0, c[11:0]}; end
      4'h1: begin m_gain = int'(c[7:0]); e = {8'h10, c[7:0]}; end
      4'h4: e = {4'h4, 12'(m_off)};
      4'h5: e = {8'h50, 8'(m_gain)};
      default: e = 16'hEEEE;
    endcase
  endtask

  task automatic pulse_cmd(input logic [15:0] c);
    cmd = c;
    cmd_rdy = 1'b1;
    @(negedge clk);
    cmd_rdy = 1'b0;
  endtask

  task automatic finish_tx(input logic [15:0] e, input string tag);
    @(negedge clk);
    repeat ($urandom_range(0, 3)) @(negedge clk);
    n_vec++;
    if (resp !== e) begin
      n_err++;
      $display("FAIL %s hold: resp=%h expected %h", tag, resp, e);
    end
    tx_done = 1'b1;
    @(negedge clk);
    tx_done = 1'b0;
    n_vec++;
    if (busy !== 1'b0) begin
      n_err++;
      $display("FAIL %s idle: busy=%b expected 0", tag, busy);
    end
  endtask

  task automatic do_simple(input logic [15:0] c, input string tag);
    logic [15:0] e;
    simple_exp(c, e);
    pulse_cmd(c);
    n_vec++;
    if (trmt !== 1'b1 || resp !== e) begin
      n_err++;
      $display("FAIL %s: trmt=%b resp=%h expected trmt=1 resp=%h",
               tag, trmt, resp, e);
    end
    finish_tx(e, tag);
  endtask

  task automatic do_read(input bit avg, input int raws[4],
                         input bit inject, input string tag);
    int n, sum, pulses;
    logic [15:0] e;
    n = avg ? 4 : 1;
    sum = 0;
    pulses = 0;
    pulse_cmd({avg ? 4'h3 : 4'h2, 12'($urandom)});
    for (int i = 0; i < n; i++) begin
      n_vec++;
      if (strt_cnv !== 1'b1) begin
        n_err++;
        $display("FAIL %s strt[%0d]: strt_cnv=%b expected 1", tag, i, strt_cnv);
      end
      if (strt_cnv === 1'b1) pulses++;
      repeat ($urandom_range(1, 6)) begin
        if (inject && i == 0) begin
          cmd = 16'h0123;
          cmd_rdy = 1'b1;
        end
        @(negedge clk);
        cmd_rdy = 1'b0;
        if (strt_cnv === 1'b1) pulses++;
      end
      a2d_raw = 12'(raws[i]);
      cnv_cmplt = 1'b1;
      sum += raws[i];
      @(negedge clk);
      cnv_cmplt = 1'b0;
    end
    if (strt_cnv === 1'b1) pulses++;
    n_vec++;
    if (trmt !== 1'b0) begin
      n_err++;
      $display("FAIL %s early: trmt=%b expected 0", tag, trmt);
    end
    @(negedge clk);
    if (strt_cnv === 1'b1) pulses++;
    e = {avg ? 4'h3 : 4'h2, 12'(model_temp(sum, n, m_off, m_gain))};
    n_vec++;
    if (trmt !== 1'b1 || resp !== e) begin
      n_err++;
      $display("FAIL %s resp: trmt=%b resp=%h expected trmt=1 resp=%h",
               tag, trmt, resp, e);
    end
    n_vec++;
    if (pulses != n) begin
      n_err++;
      $display("FAIL %s pulses: strt_cnv count=%0d expected %0d", tag, pulses, n);
    end
    finish_tx(e, tag);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    n_vec++;
    if (trmt !== 1'b0 || strt_cnv !== 1'b0 || busy !== 1'b0 || resp !== 16'h0) begin
      n_err++;
      $display("FAIL reset: trmt=%b strt=%b busy=%b resp=%h expected 0 0 0 0000",
               trmt, strt_cnv, busy, resp);
    end
    rst_n = 1'b1;
    @(negedge clk);
    m_off = 0;
    m_gain = 128;
    do_simple(16'h5000, "reset_gain");
  endtask

  task automatic test_reg_access();
    do_simple(16'h000B, "wr_off");
    do_simple(16'h4000, "rd_off");
    do_simple(16'h1080, "wr_gain");
    do_simple(16'h5000, "rd_gain");
  endtask

  task automatic test_rd_temp();
    int r[4];
    r = '{32'h100, 0, 0, 0};
    do_simple(16'h000B, "t_off");
    do_simple(16'h1080, "t_gain");
    do_read(1'b0, r, 1'b0, "rd_temp");
  endtask

  task automatic test_clamps();
    int r[4];
    do_simple(16'h0F00, "c_off_neg");
    r = '{32'h050, 0, 0, 0};
    do_read(1'b0, r, 1'b0, "clamp_low");
    do_simple(16'h0000, "c_off_zero");
    do_simple(16'h10FF, "c_gain_max");
    r = '{32'hC00, 0, 0, 0};
    do_read(1'b0, r, 1'b0, "clamp_high");
  endtask

  task automatic test_rd_avg();
    int r[4];
    do_simple(16'h1080, "a_gain");
    r = '{32'h100, 32'h102, 32'h104, 32'h106};
    do_read(1'b1, r, 1'b0, "rd_avg");
  endtask

  task automatic test_timeout();
    int cyc;
    int r[4];
    pulse_cmd(16'h2000);
    n_vec++;
    if (strt_cnv !== 1'b1) begin
      n_err++;
      $display("FAIL tmo strt: strt_cnv=%b expected 1", strt_cnv);
    end
    cyc = 0;
    while (trmt !== 1'b1 && cyc < 1200) begin
      @(negedge clk);
      cyc++;
    end
    n_vec++;
    if (trmt !== 1'b1 || resp !== 16'hFFFF) begin
      n_err++;
      $display("FAIL timeout: trmt=%b resp=%h expected trmt=1 resp=ffff", trmt, resp);
    end
    n_vec++;
    if (cyc < 1020 || cyc > 1030) begin
      n_err++;
      $display("FAIL tmo_len: cycles=%0d expected about 1025", cyc);
    end
    @(negedge clk);
    a2d_raw = 12'hFFF;
    cnv_cmplt = 1'b1;
    @(negedge clk);
    cnv_cmplt = 1'b0;
    finish_tx(16'hFFFF, "tmo_tx");
    r = '{$urandom_range(0, 4095), 0, 0, 0};
    do_read(1'b0, r, 1'b0, "after_tmo");
  endtask

  task automatic test_illegal();
    do_simple(16'h0123, "i_off");
    do_simple(16'h1045, "i_gain");
    do_simple(16'h7123, "illegal");
    for (int i = 0; i < 3; i++) begin
      do_simple({4'($urandom_range(6, 15)), 12'($urandom)}, "illegal_rnd");
    end
    do_simple(16'h4000, "i_rd_off");
    do_simple(16'h5000, "i_rd_gain");
  endtask

  task automatic test_drop();
    int r[4];
    int hits;
    do_simple(16'h0005, "d_off");
    do_simple(16'h1080, "d_gain");
    r = '{32'h200, 0, 0, 0};
    do_read(1'b0, r, 1'b1, "drop_cnv");
    do_simple(16'h4000, "drop_rd_off");
    pulse_cmd(16'h5000);
    @(negedge clk);
    tx_done = 1'b1;
    cmd = 16'h0ABC;
    cmd_rdy = 1'b1;
    @(negedge clk);
    tx_done = 1'b0;
    cmd_rdy = 1'b0;
    hits = 0;
    repeat (8) begin
      if (trmt === 1'b1 || busy === 1'b1) hits++;
      @(negedge clk);
    end
    n_vec++;
    if (hits != 0) begin
      n_err++;
      $display("FAIL drop_tx: busy/trmt cycles=%0d expected 0", hits);
    end
    do_simple(16'h4000, "drop_tx_rd");
  endtask

  task automatic test_reset_mid();
    int hits;
    do_simple(16'h0123, "r_off");
    pulse_cmd(16'h2000);
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    m_off = 0;
    m_gain = 128;
    n_vec++;
    if (busy !== 1'b0 || strt_cnv !== 1'b0 || trmt !== 1'b0 || resp !== 16'h0) begin
      n_err++;
      $display("FAIL rst_mid: busy=%b strt=%b trmt=%b resp=%h expected 0 0 0 0000",
               busy, strt_cnv, trmt, resp);
    end
    hits = 0;
    for (int i = 0; i < 10; i++) begin
      tx_done = (i == 2);
      @(negedge clk);
      if (trmt === 1'b1 || busy === 1'b1) hits++;
    end
    tx_done = 1'b0;
    n_vec++;
    if (hits != 0) begin
      n_err++;
      $display("FAIL rst_quiet: busy/trmt cycles=%0d expected 0", hits);
    end
    do_simple(16'h4000, "rst_rd_off");
    do_simple(16'h5000, "rst_rd_gain");
  endtask

  task automatic test_random();
    int r[4];
    int k;
    for (int it = 0; it < 40; it++) begin
      k = $urandom_range(0, 5);
      r = '{$urandom_range(0, 4095), $urandom_range(0, 4095),
            $urandom_range(0, 4095), $urandom_range(0, 4095)};
      case (k)
        0: do_simple({4'h0, 12'($urandom)}, "rnd_wr_off");
        1: do_simple({4'h1, 12'($urandom)}, "rnd_wr_gain");
        2: do_simple({4'($urandom_range(4, 5)), 12'($urandom)}, "rnd_rd_reg");
        3: do_read(1'b0, r, 1'b0, "rnd_temp");
        4: do_read(1'b1, r, 1'b0, "rnd_avg");
        default: do_simple({4'($urandom_range(6, 15)), 12'($urandom)}, "rnd_ill");
      endcase
    end
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_reg_access();
    test_rd_temp();
    test_clamps();
    test_rd_avg();
    test_timeout();
    test_illegal();
    test_drop();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/tsic_seq.md
# tsic_seq

Command sequencer for the TSIC. It sits between `serial_comm`, which delivers 16-bit host commands and transmits 16-bit responses, and the PTAT/A2D conversion datapath. It decodes opcodes, holds the offset and gain calibration registers, and sequences one conversion or four averaged conversions. It applies calibration with saturation and returns exactly one response per accepted command.

## Interface
- `CNV_TIMEOUT`, default 1024: cycles allowed per conversion before the error response.
- `clk`  in  1  system clock; all logic on the rising edge.
- `rst_n`  in  1  reset, synchronous, active-low.
- `cmd_rdy`  in  1  one-cycle pulse from `serial_comm`; `cmd` is valid.
- `cmd`  in  16  `[15:12]` opcode, `[11:0]` data.
- `tx_done`  in  1  pulse from `serial_comm` when the response byte stream has finished.
- `trmt`  out  1  one-cycle pulse; starts transmission of `resp`.
- `resp`  out  16  response word, held stable from `trmt` until `tx_done`.
- `strt_cnv`  out  1  one-cycle pulse; starts one A2D conversion.
- `cnv_cmplt`  in  1  one-cycle pulse; `a2d_raw` is valid.
- `a2d_raw`  in  12  raw unsigned PTAT reading.
- `busy`  out  1  high in every state other than IDLE.

## Operation
- Opcodes and responses:
  - 0 WR_OFF: `offset <= cmd[11:0]` (signed 12-bit); resp `{4'h0, offset}`.
  - 1 WR_GAIN: `gain <= cmd[7:0]` (unsigned Q1.7); resp `{4'h1, 4'h0, gain}`.
  - 2 RD_TEMP: one conversion; resp `{4'h2, temp}`.
  - 3 RD_AVG: four conversions; resp `{4'h3, temp}`.
  - 4 RD_OFF: resp `{4'h4, offset}`.
  - 5 RD_GAIN: resp `{4'h5, 4'h0, gain}`.
  - 6..F: illegal; resp 16'hEEEE; no register change.
- Calibration:
  - `avg` is the single raw reading, or the 14-bit sum of four readings shifted right by 2 (truncating).
  - `s = avg + sext(offset)`, 14-bit signed, clamped to 0..4095.
  - `t = (s * gain) >> 7`, 20-bit product, clamped to 4095.
- States:
  - IDLE: on `cmd_rdy`, latch opcode and data. Writes and register reads go to SEND, with the register update made on that edge. RD_TEMP and RD_AVG go to START. Illegal opcodes go to SEND.
  - START: pulse `strt_cnv`, clear the timeout counter, go to WAIT_CNV.
  - WAIT_CNV: on `cnv_cmplt`, add `a2d_raw` into the accumulator and increment the sample count. If the count is below the target (1 or 4), go to START; otherwise go to CALC. If the counter reaches `CNV_TIMEOUT`, load resp 16'hFFFF and go to SEND.
  - CALC: register the calibrated result into `resp`, go to SEND.
  - SEND: pulse `trmt`, go to WAIT_TX.
  - WAIT_TX: on `tx_done`, go to IDLE.
- `cmd_rdy` outside IDLE is dropped with no response, including when it coincides with `tx_done` in WAIT_TX.
- A late `cnv_cmplt` outside WAIT_CNV is ignored.

## Timing
- Reset values: state IDLE; `offset` 0; `gain` 8'h80 (unity); accumulator, counters and `resp` 0; `trmt`, `strt_cnv` and `busy` 0.
- Reset mid-operation aborts immediately to the reset values, with no response. Any `tx_done` that follows is ignored.
- For write, register-read and illegal commands: `cmd_rdy` sampled at edge k gives `trmt` high in cycle k+1.
- For reads: `cmd_rdy` sampled at edge k gives `strt_cnv` high in cycle k+1.
- After the final `cnv_cmplt` at edge m, `trmt` is high in cycle m+2.
- For RD_AVG, `strt_cnv` for the next sample is high in the cycle after the previous `cnv_cmplt`.
- The timeout counter restarts at every START. The timeout check has priority over a `cnv_cmplt` arriving in the same cycle.
- A new write takes effect for a read issued in any later command.

## Structure
- Package `tsic_pkg` holds:
  - opcode enum;
  - state enum;
  - constants `RESP_ILLEGAL` = 16'hEEEE, `RESP_TIMEOUT` = 16'hFFFF, `GAIN_RESET` = 8'h80.
- Sub-module `tsic_cal_math` is purely combinational. It takes the accumulator, sample count, offset and gain, and produces the 12-bit `temp` with both clamps. It is unit-tested separately.

## Test plan
- After reset, send 16'h000B, then 16'h4000 → resp 16'h000B with `trmt` one cycle after `cmd_rdy`; second resp 16'h400B.
- `offset` = 0x00B, `gain` = 0x80, send 16'h2000, model returns raw 0x100 → `strt_cnv` next cycle; resp 16'h210B two cycles after `cnv_cmplt`.
- Clamps:
  - `offset` = 0xF00, raw 0x050 → 16'h2000.
  - `offset` = 0, `gain` = 0xFF, raw 0xC00 → 16'h2FFF.
- RD_AVG with raws 0x100, 0x102, 0x104, 0x106 and `offset` 0 → exactly four `strt_cnv` pulses; resp 16'h3103.
- Error cases:
  - RD_TEMP with the model silent → 16'hFFFF after 1024 cycles.
  - Command 16'h7123 → 16'hEEEE with registers unchanged.
- Robustness:
  - `cmd_rdy` during WAIT_CNV is dropped; exactly one response follows.
  - `rst_n` low in WAIT_CNV → IDLE with no `trmt`, and `offset` reads back 0.
